// File: rtl/axi_aw_arbiter.sv
// Round-robin write arbiter: NUM_MST AXI masters share one slave AW/W port, B routed back by ID index.
// Optional watchdog enabled by defining AXI_AW_ARB_TIMEOUT_EN (otherwise timeout_err is tied to 0).

module axi_aw_arbiter #(
    parameter int NUM_MST = 4,
    parameter int ADDR_W  = 8,
    parameter int ID_W    = 8,
    parameter int DATA_W  = 8,
    localparam int IDX_W  = $clog2(NUM_MST),
    localparam int AW_W   = ID_W + ADDR_W + 13,
    localparam int W_W    = DATA_W + DATA_W / 8 + 1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_MST-1:0]        m_awvalid,
    output logic [NUM_MST-1:0]        m_awready,
    input  logic [NUM_MST*AW_W-1:0]   m_aw,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [AW_W+IDX_W-1:0]     s_aw,
    input  logic [NUM_MST-1:0]        m_wvalid,
    output logic [NUM_MST-1:0]        m_wready,
    input  logic [NUM_MST*W_W-1:0]    m_w,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic [W_W-1:0]            s_w,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    input  logic [ID_W+IDX_W-1:0]     s_bid,
    input  logic [1:0]                s_bresp,
    output logic [NUM_MST-1:0]        m_bvalid,
    input  logic [NUM_MST-1:0]        m_bready,
    output logic [ID_W-1:0]           m_bid,
    output logic [1:0]                m_bresp,
    output logic [NUM_MST-1:0]        grant,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] bk;
    logic             aw_hs;
    logic             w_hs;
    logic             w_last_hs;

    // Nearest requester after 'last' wins; 'last' itself has lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] ix;
        int               idx;
        pick = last;
        for (int n = NUM_MST; n >= 1; n--) begin
            idx = (int'(last) + n) % NUM_MST;
            ix  = IDX_W'(idx);
            if (req[ix]) pick = ix;
        end
        return pick;
    endfunction

    assign nxt_idx   = rr_pick(m_awvalid, last_idx);
    assign aw_hs     = s_awvalid & s_awready;
    assign w_hs      = s_wvalid & s_wready;
    assign w_last_hs = w_hs & s_w[0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            gidx     <= '0;
            last_idx <= IDX_W'(NUM_MST - 1);
            grant    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_awvalid) begin
                        gidx  <= nxt_idx;
                        grant <= NUM_MST'(1) << nxt_idx;
                        state <= ADDR;
                    end
                end
                // A granted master that drops awvalid simply keeps us waiting here.
                ADDR: begin
                    if (aw_hs) state <= DATA;
                end
                DATA: begin
                    if (w_last_hs) begin
                        last_idx <= gidx;
                        grant    <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_awready = '0;
        s_awvalid = 1'b0;
        s_aw      = '0;
        m_wready  = '0;
        s_wvalid  = 1'b0;
        s_w       = '0;
        case (state)
            ADDR: begin
                s_awvalid       = m_awvalid[gidx];
                s_aw            = {gidx, m_aw[int'(gidx)*AW_W +: AW_W]};
                m_awready[gidx] = s_awready;
            end
            DATA: begin
                s_wvalid       = m_wvalid[gidx];
                s_w            = m_w[int'(gidx)*W_W +: W_W];
                m_wready[gidx] = s_wready;
            end
            default: ;
        endcase
    end

    // B path is independent of the FSM; unknown indices are accepted and discarded.
    assign bk      = s_bid[ID_W+IDX_W-1:ID_W];
    assign m_bid   = s_bid[ID_W-1:0];
    assign m_bresp = s_bresp;

    always_comb begin
        m_bvalid = '0;
        s_bready = 1'b1;
        for (int i = 0; i < NUM_MST; i++) begin
            if (bk == IDX_W'(i)) begin
                m_bvalid[i] = s_bvalid;
                s_bready    = m_bready[i];
            end
        end
        if (areset) begin
            m_bvalid = '0;
            s_bready = 1'b0;
        end
    end

`ifdef AXI_AW_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_err;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (state == IDLE || aw_hs || w_hs) wd_cnt <= '0;
            else                                wd_cnt <= sat_inc16(wd_cnt);
            if (wd_cnt == 16'hFFFF) wd_err <= 1'b1;
        end
    end

    assign timeout_err = wd_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Randomized scoreboard bench for axi_aw_arbiter against a transaction-level round-robin model.
module tb_axi_aw_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int ID_W  = 8;
    localparam int AW_W  = 29;
    localparam int W_W   = 10;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    logic [N-1:0]          m_awvalid, m_awready;
    logic [N*AW_W-1:0]     m_aw;
    logic                  s_awvalid, s_awready;
    logic [AW_W+IDX_W-1:0] s_aw;
    logic [N-1:0]          m_wvalid, m_wready;
    logic [N*W_W-1:0]      m_w;
    logic                  s_wvalid, s_wready;
    logic [W_W-1:0]        s_w;
    logic                  s_bvalid, s_bready;
    logic [ID_W+IDX_W-1:0] s_bid;
    logic [1:0]            s_bresp;
    logic [N-1:0]          m_bvalid, m_bready;
    logic [ID_W-1:0]       m_bid;
    logic [1:0]            m_bresp;
    logic [N-1:0]          grant;
    logic                  timeout_err;

    axi_aw_arbiter #(.NUM_MST(N), .ADDR_W(8), .ID_W(ID_W), .DATA_W(8)) dut (
        .aclk(aclk), .areset(areset),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [N-1:0] mbv;
        logic         sbr;
        logic [7:0]   bid;
        logic [1:0]   bresp;
    } bexp_t;

    bexp_t                 bq[$];
    logic [AW_W+IDX_W-1:0] awq[$];
    logic [W_W-1:0]        wq[$];
    logic [N-1:0]          glog[$];

    int checks = 0;
    int errors = 0;

    // reference model state (transaction level)
    bit           mdl_busy = 0;
    bit           mdl_data = 0;
    int           mdl_cur = 0;
    int           mdl_last = N - 1;
    int           cur_beats = 0;
    logic [N-1:0] prev_grant = '0;

    // master stimulus state
    bit             st_busy[N];
    bit             st_awdone[N];
    int             st_len[N];
    int             st_beat[N];
    int             st_gap[N];
    logic [AW_W-1:0] st_aw[N];
    logic [7:0]     st_seed[N];

    bit           cfg_on = 0;
    logic [N-1:0] cfg_mask = '0;
    int           cfg_len_min = 1;
    int           cfg_len_max = 1;
    int           cfg_gap_max = 0;
    bit           wr_hold0 = 0;
    bit           to_stall = 0;
    logic         exp_to = 1'b0;
    logic [N-1:0] aw_hs_rec = '0;
    logic [N-1:0] w_hs_rec = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W_W-1:0] wbeat(input logic [7:0] seed, input int beat, input int len);
        logic [7:0] d;
        d = seed + 8'(beat * 37);
        return {d, d[0], (beat == len - 1)};
    endfunction

    function automatic int rr(input int last, input logic [N-1:0] req);
        for (int n = 1; n <= N; n++)
            if (req[(last + n) % N]) return (last + n) % N;
        return last;
    endfunction

    task automatic drive();
        bexp_t be;
        int    k;
        for (int i = 0; i < N; i++) begin
            if (areset) begin
                st_busy[i] = 0; st_awdone[i] = 0; st_beat[i] = 0; st_gap[i] = 0; st_len[i] = 0;
            end else begin
                if (aw_hs_rec[i]) st_awdone[i] = 1;
                if (w_hs_rec[i])  st_beat[i]++;
                if (st_busy[i] && st_awdone[i] && st_beat[i] >= st_len[i]) begin
                    st_busy[i] = 0;
                    st_gap[i]  = $urandom_range(cfg_gap_max, 0);
                end else if (!st_busy[i]) begin
                    if (st_gap[i] > 0) st_gap[i]--;
                    else if (cfg_on && cfg_mask[i]) begin
                        st_busy[i]   = 1;
                        st_awdone[i] = 0;
                        st_beat[i]   = 0;
                        st_len[i]    = $urandom_range(cfg_len_max, cfg_len_min);
                        st_seed[i]   = 8'($urandom);
                        st_aw[i]     = {8'($urandom), 8'($urandom), 8'(st_len[i] - 1),
                                        3'($urandom), 2'($urandom)};
                    end
                end
            end
            m_awvalid[i] = st_busy[i] && !st_awdone[i];
            m_aw[i*AW_W +: AW_W] = st_aw[i];
            m_wvalid[i] = st_busy[i] && (st_beat[i] < st_len[i]);
            m_w[i*W_W +: W_W] = wbeat(st_seed[i], st_beat[i], st_len[i]);
        end
        s_awready = ($urandom_range(2, 0) != 0);
        s_wready  = wr_hold0 ? 1'b0 : ($urandom_range(3, 0) != 0);
        s_bvalid  = 1'($urandom);
        s_bid     = 10'($urandom);
        s_bresp   = 2'($urandom);
        m_bready  = 4'($urandom);
        k         = int'(s_bid[9:8]);
        be.mbv    = s_bvalid ? 4'(1 << k) : 4'b0;
        be.sbr    = m_bready[k];
        be.bid    = s_bid[7:0];
        be.bresp  = s_bresp;
        bq.push_back(be);
    endtask

    task automatic monitor();
        bexp_t          be;
        bit             busy0, in_addr, in_data;
        logic [W_W-1:0] we;
        be = '0;
        if (bq.size() > 0) be = bq.pop_front();
        if (areset) begin
            chk("reset_outputs", {grant, m_awready, s_awvalid, m_wready, s_wvalid,
                                  m_bvalid, s_bready, timeout_err}, 64'd0);
            awq.delete(); wq.delete();
            aw_hs_rec = '0; w_hs_rec = '0;
            mdl_busy = 0; mdl_data = 0; mdl_last = N - 1; cur_beats = 0;
            prev_grant = '0;
            return;
        end
        busy0   = mdl_busy;
        in_addr = mdl_busy && !mdl_data;
        in_data = mdl_busy && mdl_data;
        chk("grant", grant, mdl_busy ? 4'(1 << mdl_cur) : 4'b0);
        chk("s_awvalid", s_awvalid, in_addr ? m_awvalid[mdl_cur] : 1'b0);
        chk("m_awready", m_awready, in_addr ? 4'({3'b0, s_awready} << mdl_cur) : 4'b0);
        chk("s_wvalid", s_wvalid, in_data ? m_wvalid[mdl_cur] : 1'b0);
        chk("m_wready", m_wready, in_data ? 4'({3'b0, s_wready} << mdl_cur) : 4'b0);
        chk("b_route", {m_bvalid, s_bready, m_bid, m_bresp}, be);
        if (!to_stall) chk("timeout_err", timeout_err, exp_to);
        if (grant != 0 && prev_grant == 0) glog.push_back(grant);
        prev_grant = grant;
        if (s_awvalid && s_awready) begin
            if (awq.size() == 0) chk("aw_unexpected", s_aw, 64'd0);
            else chk("s_aw", s_aw, awq.pop_front());
            if (in_addr) mdl_data = 1;
        end
        if (s_wvalid && s_wready) begin
            if (wq.size() == 0) chk("w_unexpected", s_w, 64'd0);
            else begin
                we = wq.pop_front();
                chk("s_w", s_w, we);
                cur_beats++;
                if (we[0]) begin
                    mdl_busy = 0; mdl_data = 0; mdl_last = mdl_cur;
                end
            end
        end
        if (!busy0 && m_awvalid != 0) begin
            mdl_cur   = rr(mdl_last, m_awvalid);
            mdl_busy  = 1;
            mdl_data  = 0;
            cur_beats = 0;
            awq.push_back({2'(mdl_cur), m_aw[mdl_cur*AW_W +: AW_W]});
            for (int b = 0; b < st_len[mdl_cur]; b++)
                wq.push_back(wbeat(st_seed[mdl_cur], b, st_len[mdl_cur]));
        end
        aw_hs_rec = m_awvalid & m_awready;
        w_hs_rec  = m_wvalid & m_wready;
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            drive();
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            #2;
            monitor();
        end
    end

    task automatic drain();
        bit done;
        bit any;
        done = 0;
        cfg_on = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge aclk);
            #3;
            any = 0;
            for (int i = 0; i < N; i++) if (st_busy[i]) any = 1;
            if (!mdl_busy && !any) done = 1;
        end
        chk("drain_done", done, 1'b1);
    endtask

    initial begin
        bit hit;
        m_awvalid = '0; m_aw = '0; m_wvalid = '0; m_w = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0;
        s_bresp = '0; m_bready = '0;
        repeat (3) @(negedge aclk);
        #1 areset = 1'b0;

        // single master, single-beat burst
        cfg_mask = 4'b0001; cfg_len_min = 1; cfg_len_max = 1; cfg_gap_max = 40; cfg_on = 1;
        repeat (40) @(negedge aclk);
        chk("single_grant_seen", glog.size() >= 1, 1'b1);
        if (glog.size() >= 1) chk("single_grant", glog[0], 4'b0001);

        // all masters requesting back-to-back, two beats each
        @(negedge aclk);
        #1 areset = 1'b1;
        glog.delete();
        cfg_mask = 4'b1111; cfg_len_min = 2; cfg_len_max = 2; cfg_gap_max = 0; cfg_on = 1;
        repeat (2) @(negedge aclk);
        #1 areset = 1'b0;
        for (int n = 0; n < 400 && glog.size() < 5; n++) @(negedge aclk);
        chk("rr_log_len", glog.size() >= 5, 1'b1);
        if (glog.size() >= 5) begin
            chk("rr_order0", glog[0], 4'b0001);
            chk("rr_order1", glog[1], 4'b0010);
            chk("rr_order2", glog[2], 4'b0100);
            chk("rr_order3", glog[3], 4'b1000);
            chk("rr_order4", glog[4], 4'b0001);
        end

        // randomized traffic with changing request masks
        cfg_len_min = 1; cfg_len_max = 4; cfg_gap_max = 6;
        for (int r = 0; r < 15; r++) begin
            cfg_mask = 4'($urandom_range(15, 1));
            repeat (200) @(negedge aclk);
        end

        // reset in the middle of a 4-beat burst from master 2
        drain();
        cfg_mask = 4'b0100; cfg_len_min = 4; cfg_len_max = 4; cfg_gap_max = 0; cfg_on = 1;
        hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge aclk);
            #3;
            if (mdl_busy && mdl_data && cur_beats == 1) hit = 1;
        end
        chk("midburst_reached", hit, 1'b1);
        #3 areset = 1'b1;
        #1 chk("midburst_reset_outputs", {grant, m_awready, s_awvalid, m_wready, s_wvalid,
                                          m_bvalid, s_bready, timeout_err}, 64'd0);
        glog.delete();
        cfg_mask = 4'b1111; cfg_len_min = 1; cfg_len_max = 3;
        repeat (2) @(negedge aclk);
        #1 areset = 1'b0;
        repeat (100) @(negedge aclk);
        chk("post_reset_log", glog.size() >= 1, 1'b1);
        if (glog.size() >= 1) chk("post_reset_grant", glog[0], 4'b0001);

`ifdef AXI_AW_ARB_TIMEOUT_EN
        drain();
        cfg_mask = 4'b0001; cfg_len_min = 4; cfg_len_max = 4; cfg_gap_max = 100; cfg_on = 1;
        hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge aclk);
            #3;
            if (mdl_busy && mdl_data) hit = 1;
        end
        chk("stall_data_reached", hit, 1'b1);
        to_stall = 1;
        wr_hold0 = 1;
        repeat (65600) @(negedge aclk);
        #3 chk("timeout_set", timeout_err, 1'b1);
        exp_to   = 1'b1;
        wr_hold0 = 0;
        to_stall = 0;
        repeat (50) @(negedge aclk);
        #3 chk("timeout_sticky", timeout_err, 1'b1);
`endif

        drain();
        chk("aw_queue_empty", awq.size(), 64'd0);
        chk("w_queue_empty", wq.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
